// File: rtl/acc_drain_pkg.sv
// Shared types, derived widths and the lane saturation helper for the
// accumulator drain path.
`ifndef DIM_C
`define DIM_C 2
`endif
`ifndef DIM_A
`define DIM_A 2
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 8
`endif
`ifndef DIM_B
`define DIM_B 4
`endif

package acc_drain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    STREAM
  } drain_state_e;

  localparam int unsigned SUM_W     = `ACC_WIDTH + `DIM_B;
  localparam int unsigned ROW_W     = (`DIM_C > 1) ? $clog2(`DIM_C) : 1;
  localparam int unsigned SAT_MAX_W = 64;

  function automatic logic [SAT_MAX_W-1:0] lane_limit(input int unsigned out_w);
    return (out_w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << out_w) - SAT_MAX_W'(1));
  endfunction

  // Clamp an unsigned value to the largest value representable in out_w bits.
  function automatic logic [SAT_MAX_W-1:0] sat_lane(input logic [SAT_MAX_W-1:0] v,
                                                    input int unsigned out_w);
    return (v > lane_limit(out_w)) ? lane_limit(out_w) : v;
  endfunction

endpackage

// File: rtl/drain_sat_row.sv
// Combinational saturation of one row of DIM_A accumulator lanes to OUT_WIDTH,
// with a flag raised when any lane was clipped.
module drain_sat_row
  import acc_drain_pkg::*;
#(
  parameter int unsigned DIM_A     = `DIM_A,
  parameter int unsigned SUM_W     = `ACC_WIDTH + `DIM_B,
  parameter int unsigned OUT_WIDTH = `ACC_WIDTH
) (
  input  logic [DIM_A-1:0][SUM_W-1:0]     row_in,
  output logic [DIM_A-1:0][OUT_WIDTH-1:0] row_out,
  output logic                            sat_any
);

  logic [DIM_A-1:0] lane_sat;

  for (genvar g = 0; g < DIM_A; g++) begin : g_lane
    logic [SAT_MAX_W-1:0] wide;
    logic [SAT_MAX_W-1:0] clip;

    assign wide          = SAT_MAX_W'(row_in[g]);
    assign clip          = sat_lane(wide, OUT_WIDTH);
    assign row_out[g]    = clip[OUT_WIDTH-1:0];
    assign lane_sat[g]   = (clip != wide);
  end

  assign sat_any = |lane_sat;

endmodule

// File: rtl/acc_prod_drain.sv
// Drain controller: snapshots the accumulator sum array, pulses the clear and
// streams saturated rows over a valid/ready interface.
module acc_prod_drain
  import acc_drain_pkg::*;
#(
  parameter int unsigned DIM_C     = `DIM_C,
  parameter int unsigned DIM_A     = `DIM_A,
  parameter int unsigned ACC_WIDTH = `ACC_WIDTH,
  parameter int unsigned DIM_B     = `DIM_B,
  parameter int unsigned OUT_WIDTH = `ACC_WIDTH,
  localparam int unsigned SUM_W    = ACC_WIDTH + DIM_B,
  localparam int unsigned ROW_W    = (DIM_C > 1) ? $clog2(DIM_C) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [DIM_C-1:0][DIM_A-1:0][SUM_W-1:0] sum,
  input  logic                                 start,
  output logic                                 start_ready,
  output logic                                 acc_clear,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DIM_A-1:0][OUT_WIDTH-1:0]      out_data,
  output logic [ROW_W-1:0]                     out_row,
  output logic                                 out_last,
  output logic                                 sat_flag,
  output logic                                 done
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DIM_C - 1);

  drain_state_e state, state_nx;

  logic [DIM_C-1:0][DIM_A-1:0][SUM_W-1:0] shadow;
  logic [ROW_W-1:0]                     row;
  logic [DIM_A-1:0][OUT_WIDTH-1:0]      row_sat;
  logic                                 row_sat_any;
  logic                                 out_sat;
  logic                                 start_fire;
  logic                                 beat_fire;
  logic                                 load_beat;

  drain_sat_row #(
    .DIM_A    (DIM_A),
    .SUM_W    (SUM_W),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_sat_row (
    .row_in (shadow[row]),
    .row_out(row_sat),
    .sat_any(row_sat_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start_fire = 1'b0;
    beat_fire  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          start_fire = 1'b1;
          state_nx   = CLR;
        end
      end
      CLR: state_nx = STREAM;
      STREAM: begin
        if (out_ready) begin
          beat_fire = 1'b1;
          if (out_last) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    load_beat = (state == CLR) || (beat_fire && !out_last);
  end

  assign start_ready = (state == IDLE);

  // row is a fetch pointer running one beat ahead of out_row, so each
  // presented beat is already registered when the previous one handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
      sat_flag  <= 1'b0;
      acc_clear <= 1'b0;
      done      <= 1'b0;
    end else begin
      acc_clear <= 1'b0;
      done      <= 1'b0;
      if (start_fire) begin
        shadow    <= sum;
        row       <= '0;
        sat_flag  <= 1'b0;
        acc_clear <= 1'b1;
      end
      if (load_beat) begin
        out_data <= row_sat;
        out_sat  <= row_sat_any;
        out_row  <= row;
        out_last <= (row == ROW_LAST);
        if (row != ROW_LAST) row <= row + ROW_W'(1);
      end
      if (state == CLR) out_valid <= 1'b1;
      if (beat_fire) begin
        sat_flag <= sat_flag | out_sat;
        if (out_last) begin
          out_valid <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_prod_drain.sv
// Self-checking bench for acc_prod_drain with a captured-array reference model.
module tb_acc_prod_drain;

  localparam int unsigned DC = 2;
  localparam int unsigned DA = 2;
  localparam int unsigned AW = 8;
  localparam int unsigned DB = 4;
  localparam int unsigned SW = AW + DB;
  localparam int unsigned OW = 8;
  localparam int unsigned OMAX = (1 << OW) - 1;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [DC-1:0][DA-1:0][SW-1:0] sum;
  logic                          start;
  logic                          start_ready;
  logic                          acc_clear;
  logic                          out_valid;
  logic                          out_ready;
  logic [DA-1:0][OW-1:0]         out_data;
  logic [0:0]                    out_row;
  logic                          out_last;
  logic                          sat_flag;
  logic                          done;

  int checks   = 0;
  int failures = 0;
  int unsigned cap [DC][DA];

  always #5 clk = ~clk;

  acc_prod_drain #(
    .DIM_C    (DC),
    .DIM_A    (DA),
    .ACC_WIDTH(AW),
    .DIM_B    (DB),
    .OUT_WIDTH(OW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sum        (sum),
    .start      (start),
    .start_ready(start_ready),
    .acc_clear  (acc_clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_last   (out_last),
    .sat_flag   (sat_flag),
    .done       (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DA*OW-1:0] exp_row(input int unsigned r);
    logic [DA*OW-1:0] e;
    e = '0;
    for (int l = 0; l < DA; l++)
      e[l*OW +: OW] = OW'((cap[r][l] > OMAX) ? OMAX : cap[r][l]);
    return e;
  endfunction

  function automatic bit row_sat(input int unsigned r);
    bit s;
    s = 1'b0;
    for (int l = 0; l < DA; l++)
      if (cap[r][l] > OMAX) s = 1'b1;
    return s;
  endfunction

  task automatic apply_cap();
    for (int r = 0; r < DC; r++)
      for (int l = 0; l < DA; l++)
        sum[r][l] = SW'(cap[r][l]);
  endtask

  task automatic set_cap(input int unsigned a, input int unsigned b,
                         input int unsigned c, input int unsigned d);
    cap[0][0] = a; cap[0][1] = b; cap[1][0] = c; cap[1][1] = d;
    apply_cap();
  endtask

  // One complete drain from the current (IDLE) cycle through the done pulse,
  // checked cycle by cycle against the captured array.
  task automatic run_drain(input int unsigned stall0, input int unsigned stall_max,
                           input bit corrupt, input bit poke);
    bit exp_sat;
    int unsigned stalls;
    exp_sat = 1'b0;
    chk("idle_start_ready", start_ready, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("clr_acc_clear", acc_clear, 1);
    chk("clr_start_ready", start_ready, 0);
    chk("clr_valid", out_valid, 0);
    chk("clr_sat_flag", sat_flag, 0);
    chk("clr_done", done, 0);
    if (corrupt) sum = '1;
    if (poke) start = 1'b1;
    step();
    for (int r = 0; r < DC; r++) begin
      stalls = (stall_max > 0) ? $urandom_range(0, stall_max) : 0;
      if (r == 0) stalls += stall0;
      for (int c = 0; c <= int'(stalls); c++) begin
        out_ready = (c == int'(stalls));
        chk("beat_valid", out_valid, 1);
        chk("beat_data", out_data, exp_row(r));
        chk("beat_row", out_row, r);
        chk("beat_last", out_last, (r == DC - 1));
        chk("beat_acc_clear", acc_clear, 0);
        chk("beat_start_ready", start_ready, 0);
        chk("beat_done", done, 0);
        chk("beat_sat_flag", sat_flag, exp_sat);
        step();
      end
      exp_sat |= row_sat(r);
    end
    start     = 1'b0;
    out_ready = 1'($urandom_range(0, 1));
    chk("done_pulse", done, 1);
    chk("done_valid", out_valid, 0);
    chk("done_start_ready", start_ready, 1);
    chk("done_sat_flag", sat_flag, exp_sat);
    chk("done_acc_clear", acc_clear, 0);
  endtask

  initial begin
    rst_n     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    sum       = '0;
    #2 rst_n  = 1'b0;
    step();
    step();
    chk("rst_start_ready", start_ready, 1);
    chk("rst_acc_clear", acc_clear, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_row", out_row, 0);
    chk("rst_last", out_last, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    step();

    // Basic drain with one saturating lane, then an idle cycle.
    set_cap(5, 7, 300, 9);
    run_drain(0, 0, 1'b0, 1'b0);
    step();
    chk("post_done_low", done, 0);

    // Backpressure on beat0.
    set_cap(17, 200, 4095, 256);
    run_drain(3, 0, 1'b0, 1'b0);
    step();

    // Snapshot isolation, then start pulsed while busy.
    set_cap(12, 34, 56, 78);
    run_drain(0, 0, 1'b1, 1'b0);
    set_cap(1000, 3, 4, 5);
    run_drain(1, 1, 1'b0, 1'b1);
    // Start in the done cycle, no saturation.
    set_cap(255, 0, 1, 2);
    run_drain(0, 0, 1'b0, 1'b0);
    step();

    // Reset in the middle of the stream.
    set_cap(400, 1, 2, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pre_rst_sat_flag", sat_flag, 1);
    chk("pre_rst_row", out_row, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_start_ready", start_ready, 1);
    chk("mid_rst_sat_flag", sat_flag, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_acc_clear", acc_clear, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_done", done, 0);
    chk("post_rst_valid", out_valid, 0);
    set_cap(10, 20, 30, 40);
    run_drain(0, 0, 1'b0, 1'b0);
    step();

    // Randomised drains.
    for (int n = 0; n < 25; n++) begin
      for (int r = 0; r < DC; r++)
        for (int l = 0; l < DA; l++)
          cap[r][l] = ($urandom_range(0, 2) == 0) ? $urandom_range(0, (1 << SW) - 1)
                                                 : $urandom_range(0, OMAX);
      apply_cap();
      run_drain(0, 3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) step();
    end
    step();
    chk("final_done_low", done, 0);
    chk("final_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_prod_drain.md
Name: acc_prod_drain

Overview:
- Read-side partner of the product accumulator array.
- On a drain request it snapshots the full DIM_C x DIM_A sum array into a shadow register and pulses the accumulator clear, so the next tile can start accumulating at once.
- It then streams the snapshot row by row (one DIM_C row of DIM_A lanes per beat) over a valid/ready interface.
- Each lane is saturated to OUT_WIDTH. Sits between the accumulator array and the output writeback/SRAM path.

Parameters:
- DIM_C, `DIM_C: number of rows (output channels); one beat per row.
- DIM_A, `DIM_A: lanes per row.
- ACC_WIDTH, `ACC_WIDTH: accumulator input width.
- DIM_B, `DIM_B: accumulation headroom bits. SUM_W = ACC_WIDTH+DIM_B.
- OUT_WIDTH, `ACC_WIDTH: output lane width. Must be ≤ SUM_W.

Ports:
- clk  in  1  clock; all logic rises on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- sum  in  [DIM_C][DIM_A][SUM_W]  accumulator sum array, unsigned.
- start  in  1  drain request; accepted only when start_ready=1.
- start_ready  out  1  high in IDLE.
- acc_clear  out  1  registered one-cycle clear to the accumulator.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  [DIM_A][OUT_WIDTH]  saturated row.
- out_row  out  $clog2(DIM_C) (min 1)  row index of the current beat.
- out_last  out  1  high on the row DIM_C-1 beat.
- sat_flag  out  1  sticky per drain: any lane saturated. Cleared on start accept.
- done  out  1  one-cycle pulse after the last beat handshakes.

Behaviour:
- Reset values: all outputs 0, except start_ready=1. State IDLE, row counter 0, shadow register 0.
- Reset asserted mid-drain: everything returns to reset values immediately. The partial stream is abandoned, with no done and no acc_clear.
- States: IDLE, CLR, STREAM.
- IDLE:
  - start_ready=1, out_valid=0.
  - On start=1: shadow <= sum (same edge), row <= 0, sat_flag <= 0, acc_clear <= 1, go to CLR.
- CLR (exactly 1 cycle):
  - acc_clear=1, start_ready=0. Go to STREAM; acc_clear <= 0.
  - Upstream keeps accumulator enable low during this cycle. The accumulator's clear takes priority over enable.
- STREAM:
  - out_valid=1. out_data/out_row/out_last are registered, derived from shadow[row].
  - Valid/ready rules: when out_valid && !out_ready, all out_* hold stable. Valid never drops without a handshake.
  - Handshake with row<DIM_C-1: row++, next row presented on the next cycle. Back-to-back beats at 1/cycle when out_ready is held high.
  - Handshake with row==DIM_C-1: out_valid <= 0, done <= 1 for one cycle, go to IDLE.
- Latency: start accept edge -> first out_valid is 2 cycles (CLR, then STREAM). Full drain with out_ready=1 is DIM_C+2 cycles from start to the done pulse.
- Saturation, per lane: out = (shadow > 2^OUT_WIDTH-1) ? 2^OUT_WIDTH-1 : shadow[OUT_WIDTH-1:0]. Any saturated lane of a handshaken beat sets sat_flag. With OUT_WIDTH==SUM_W this is a pass-through.
- start while not IDLE: ignored, no side effects.
- DIM_C==1: a single beat with out_last=1 and out_row=0.
- sum changes after capture: no effect on the current drain.
- done and start in the same cycle: done is asserted while in IDLE, so start is accepted normally.

Decomposition:
- Shared package (acc_drain_pkg):
  - state enum.
  - SUM_W and ROW_W localparams derived from the DEF.sv macros.
  - sat_lane function.
- Sub-module drain_sat_row: combinational saturation of one DIM_A row, producing a sat_any flag. Instantiated once, fed by shadow[row].
- Top contains the FSM, shadow register, row counter and output registers.

Test Plan:
Common configuration: DIM_C=2, DIM_A=2, ACC_WIDTH=8, DIM_B=4 (SUM_W=12), OUT_WIDTH=8.
- Basic drain, out_ready=1:
  - Stimulus: sum={{5,7},{300,9}}, start for 1 cycle.
  - Expected: acc_clear high for 1 cycle; beat0 row0 data {5,7}, out_last=0; beat1 row1 data {255,9}, out_last=1; sat_flag=1; done pulse at cycle start+4; start_ready back to 1.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles on beat0.
  - Expected: out_valid, out_data and out_row stable throughout; beat1 follows only after the handshake.
- Snapshot isolation:
  - Stimulus: sum changes to all 1s during CLR/STREAM.
  - Expected: streamed data equals the values captured at start.
- start while busy:
  - Stimulus: pulse start during STREAM.
  - Expected: no second acc_clear, stream unaffected, start_ready=0.
- Reset mid-stream:
  - Stimulus: rst_n low after beat0.
  - Expected: out_valid=0 immediately, no done, start_ready=1 after release. A new drain then works normally with sat_flag reset to 0.
- No saturation:
  - Stimulus: sum={{255,0},{1,2}}.
  - Expected: data passes unchanged, sat_flag=0.
